// File: rtl/fft_bin_power_pkg.sv
// fft_bin_power_pkg: shared constants, stage tag struct and bin-width helper for the BPM FFT power stage
package bpm_fft_pkg;

    localparam int DEF_W     = 16;
    localparam int DEF_NBINS = 1024;
    localparam int MAX_BIN_W = 16;

    // Sideband carried alongside the data through every pipeline stage
    typedef struct packed {
        logic                 valid;
        logic                 sop;
        logic                 eop;
        logic [MAX_BIN_W-1:0] bin;
    } stage_t;

    function automatic int BIN_W(input int nbins);
        return $clog2(nbins);
    endfunction

endpackage

// File: rtl/fft_bin_power_if.sv
// fft_bin_power_if: streaming bins in (valid/ready, sop/eop, re/im) and power beats out (valid/ready, power, sat, bin, sop/eop)
interface fft_bin_power_if #(
    parameter int W  = 16,
    parameter int OW = 2*W+1,
    parameter int BW = 10
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sop;
    logic                 in_eop;
    logic signed [W-1:0]  in_real;
    logic signed [W-1:0]  in_imag;
    logic                 out_valid;
    logic                 out_ready;
    logic [OW-1:0]        out_power;
    logic                 out_sat;
    logic [BW-1:0]        out_bin;
    logic                 out_sop;
    logic                 out_eop;

    modport master (
        output in_valid, in_sop, in_eop, in_real, in_imag, out_ready,
        input  in_ready, out_valid, out_power, out_sat, out_bin, out_sop, out_eop
    );

    modport slave (
        input  in_valid, in_sop, in_eop, in_real, in_imag, out_ready,
        output in_ready, out_valid, out_power, out_sat, out_bin, out_sop, out_eop
    );
endinterface

// File: rtl/fft_bin_power_sat_shift.sv
// sat_shift: combinational right shift by SHIFT then saturate to OW bits (x in, y/sat out)
module sat_shift #(
    parameter int IW    = 33,
    parameter int SHIFT = 0,
    parameter int OW    = 33
) (
    input  logic [IW-1:0] x,
    output logic [OW-1:0] y,
    output logic          sat
);
    logic [IW-1:0] sh;

    always_comb begin
        sh  = x >> SHIFT;
        sat = |(sh >> OW);
        y   = sat ? '1 : sh[OW-1:0];
    end
endmodule

// File: rtl/fft_bin_power.sv
// fft_bin_power: 3-stage |X|^2 per FFT bin with shift/saturate, bin tagging, framing-error flag and frame counter
//   clk, reset     : clock, synchronous active-high reset
//   bus            : input bin stream and output power stream (fft_bin_power_if.slave)
//   err_clr        : clears the sticky frame_err
//   frame_err      : sticky framing error
//   frame_cnt      : frames delivered downstream, wraps at 16 bits
module fft_bin_power
    import bpm_fft_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int NBINS = DEF_NBINS,
    parameter int SHIFT = 0,
    parameter int OW    = 2*W+1
) (
    input  logic                 clk,
    input  logic                 reset,
    fft_bin_power_if.slave       bus,
    input  logic                 err_clr,
    output logic                 frame_err,
    output logic [15:0]          frame_cnt
);
    localparam int BW = BIN_W(NBINS);
    localparam int PW = 2*W+1;

    logic                  en;
    logic                  acc;
    stage_t                s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
    logic signed [2*W-1:0] re2_d, re2_q, im2_d, im2_q;
    logic [PW-1:0]         raw_d, raw_q;
    logic [OW-1:0]         power_d, power_q, sat_y;
    logic                  sat_d, sat_q, sat_s;
    logic [BW-1:0]         bin_d, bin_q, tag;
    logic                  need_sop_d, need_sop_q;
    logic                  err_set;
    logic                  frame_err_d, frame_err_q;
    logic [15:0]           frame_cnt_d, frame_cnt_q;
    logic                  bin_unused;

    // One global stall: the whole pipe advances only when the last stage can drain
    assign en           = !s3_q.valid || bus.out_ready;
    assign acc          = bus.in_valid && en;
    assign bus.in_ready = en;

    sat_shift #(.IW(PW), .SHIFT(SHIFT), .OW(OW)) u_sat (
        .x   (raw_q),
        .y   (sat_y),
        .sat (sat_s)
    );

    always_comb begin
        tag     = bus.in_sop ? '0 : bin_q;
        s1_d    = s1_q;
        re2_d   = re2_q;
        im2_d   = im2_q;
        s2_d    = s2_q;
        raw_d   = raw_q;
        s3_d    = s3_q;
        power_d = power_q;
        sat_d   = sat_q;
        if (en) begin
            s1_d             = '0;
            s1_d.valid       = bus.in_valid;
            s1_d.sop         = bus.in_valid && bus.in_sop;
            s1_d.eop         = bus.in_valid && bus.in_eop;
            s1_d.bin[BW-1:0] = tag;
            re2_d            = (2*W)'(bus.in_real) * (2*W)'(bus.in_real);
            im2_d            = (2*W)'(bus.in_imag) * (2*W)'(bus.in_imag);
            s2_d             = s1_q;
            raw_d            = {1'b0, re2_q} + {1'b0, im2_q};
            s3_d             = s2_q;
            power_d          = sat_y;
            sat_d            = sat_s;
        end
    end

    // need_sop marks "between frames": after reset or an accepted eop
    always_comb begin
        bin_d       = acc ? (bus.in_sop ? BW'(1) : bin_q + 1'b1) : bin_q;
        need_sop_d  = acc ? bus.in_eop : need_sop_q;
        err_set     = acc && ((bus.in_sop && !need_sop_q && bin_q != '0)
                           || (bus.in_eop && tag != BW'(NBINS-1))
                           || (!bus.in_sop && need_sop_q && bin_q == '0));
        frame_err_d = err_set || (frame_err_q && !err_clr);
        frame_cnt_d = frame_cnt_q + 16'(s3_q.valid && bus.out_ready && s3_q.eop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            re2_q       <= '0;
            im2_q       <= '0;
            raw_q       <= '0;
            power_q     <= '0;
            sat_q       <= 1'b0;
            bin_q       <= '0;
            need_sop_q  <= 1'b1;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            re2_q       <= re2_d;
            im2_q       <= im2_d;
            raw_q       <= raw_d;
            power_q     <= power_d;
            sat_q       <= sat_d;
            bin_q       <= bin_d;
            need_sop_q  <= need_sop_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Bin bits above BW are always zero in the stage struct
    assign bin_unused    = ^s3_q.bin;
    assign bus.out_valid = s3_q.valid;
    assign bus.out_power = power_q;
    assign bus.out_sat   = sat_q;
    assign bus.out_bin   = s3_q.bin[BW-1:0];
    assign bus.out_sop   = s3_q.sop;
    assign bus.out_eop   = s3_q.eop;
    assign frame_err     = frame_err_q;
    assign frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_fft_bin_power.sv
// tb_fft_bin_power: self-checking bench for fft_bin_power (SHIFT=0/OW=33 and SHIFT=4/OW=24 side by side)
module tb_fft_bin_power;
    localparam int W   = 16;
    localparam int NB  = 1024;
    localparam int BW  = 10;
    localparam int OW1 = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        err_clr = 1'b0;
    logic        ferr0, ferr1;
    logic [15:0] fcnt0, fcnt1;

    always #5 clk = ~clk;

    fft_bin_power_if #(.W(W), .OW(2*W+1), .BW(BW)) b0 ();
    fft_bin_power_if #(.W(W), .OW(OW1),   .BW(BW)) b1 ();

    assign b1.in_valid  = b0.in_valid;
    assign b1.in_sop    = b0.in_sop;
    assign b1.in_eop    = b0.in_eop;
    assign b1.in_real   = b0.in_real;
    assign b1.in_imag   = b0.in_imag;
    assign b1.out_ready = b0.out_ready;

    fft_bin_power #(.W(W), .NBINS(NB), .SHIFT(0), .OW(2*W+1)) dut0 (
        .clk(clk), .reset(reset), .bus(b0), .err_clr(err_clr), .frame_err(ferr0), .frame_cnt(fcnt0));
    fft_bin_power #(.W(W), .NBINS(NB), .SHIFT(4), .OW(OW1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1), .err_clr(err_clr), .frame_err(ferr1), .frame_cnt(fcnt1));

    typedef struct {
        longint p0;
        longint p1;
        bit     s1;
        int     bin;
        bit     sop;
        bit     eop;
    } exp_t;

    typedef struct {
        int     r;
        int     i;
        longint p0;
        longint p1;
        bit     s1;
    } vec_t;

    exp_t q[$];
    int   m_cnt;
    bit   m_need;
    bit   m_ferr;
    int   m_fcnt;
    int   checks = 0;
    int   errors = 0;
    bit   stall = 0;
    bit   last_oval = 0;
    longint h_p0, h_p1;
    int   h_bin;
    bit   h_sop, h_eop;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: power from plain integer arithmetic, shifted/clamped for the 24-bit variant
    function automatic exp_t model(input bit s, input bit e, input logic signed [15:0] r,
                                   input logic signed [15:0] i, input int bin);
        exp_t   x;
        longint p, sh;
        p     = longint'(r) * longint'(r) + longint'(i) * longint'(i);
        sh    = p / 16;
        x.p0  = p;
        x.s1  = sh > 64'd16777215;
        x.p1  = x.s1 ? 64'd16777215 : sh;
        x.bin = bin;
        x.sop = s;
        x.eop = e;
        return x;
    endfunction

    task automatic step(input bit v, input bit s, input bit e, input logic signed [15:0] r,
                        input logic signed [15:0] i, input bit ordy, input bit clr, output bit acc);
        exp_t x;
        int   tag;
        bit   err;
        @(negedge clk);
        b0.in_valid  = v;
        b0.in_sop    = s;
        b0.in_eop    = e;
        b0.in_real   = r;
        b0.in_imag   = i;
        b0.out_ready = ordy;
        err_clr      = clr;
        #1;
        last_oval = b0.out_valid;
        chk("frame_err0", ferr0, m_ferr);
        chk("frame_err1", ferr1, m_ferr);
        chk("frame_cnt0", fcnt0, m_fcnt);
        chk("frame_cnt1", fcnt1, m_fcnt);
        if (ordy) chk("in_ready_open", b0.in_ready, 1);
        if (b0.out_valid && !ordy) chk("in_ready_stall", b0.in_ready, 0);
        if (stall) begin
            chk("hold_valid", b0.out_valid, 1);
            chk("hold_power0", b0.out_power, h_p0);
            chk("hold_power1", b1.out_power, h_p1);
            chk("hold_bin", b0.out_bin, h_bin);
            chk("hold_sop", b0.out_sop, h_sop);
            chk("hold_eop", b0.out_eop, h_eop);
        end
        if (b0.out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                x = q.pop_front();
                chk("power0", b0.out_power, x.p0);
                chk("sat0", b0.out_sat, 0);
                chk("valid1", b1.out_valid, 1);
                chk("power1", b1.out_power, x.p1);
                chk("sat1", b1.out_sat, x.s1);
                chk("bin", b0.out_bin, x.bin);
                chk("sop", b0.out_sop, x.sop);
                chk("eop", b0.out_eop, x.eop);
                if (x.eop) m_fcnt = (m_fcnt + 1) % 65536;
            end
        end
        acc = v && b0.in_ready;
        err = 1'b0;
        if (acc) begin
            tag    = s ? 0 : m_cnt;
            err    = (s && !m_need && m_cnt != 0) || (e && tag != NB-1) || (!s && m_need && m_cnt == 0);
            m_cnt  = s ? 1 : (m_cnt + 1) % NB;
            m_need = e;
            q.push_back(model(s, e, r, i, tag));
        end
        m_ferr = err ? 1'b1 : (clr ? 1'b0 : m_ferr);
        stall  = b0.out_valid && !ordy;
        h_p0   = b0.out_power;
        h_p1   = b1.out_power;
        h_bin  = b0.out_bin;
        h_sop  = b0.out_sop;
        h_eop  = b0.out_eop;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b0;
        err_clr      = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out_valid", b0.out_valid, 0);
        chk("rst_out_power", b0.out_power, 0);
        chk("rst_out_sat", b0.out_sat, 0);
        chk("rst_out_bin", b0.out_bin, 0);
        chk("rst_out_sop", b0.out_sop, 0);
        chk("rst_out_eop", b0.out_eop, 0);
        chk("rst_in_ready", b0.in_ready, 1);
        chk("rst_frame_err", ferr0, 0);
        chk("rst_frame_cnt", fcnt0, 0);
        reset  = 1'b0;
        q.delete();
        m_cnt  = 0;
        m_need = 1'b1;
        m_ferr = 1'b0;
        m_fcnt = 0;
        stall  = 1'b0;
    endtask

    task automatic idle(input int n, input bit clr);
        bit acc;
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 1, clr, acc);
    endtask

    task automatic drain();
        idle(8, 0);
        chk("drain_empty", q.size(), 0);
    endtask

    // mode 0: out_ready toggles, 1: always ready, 2: random
    task automatic run_frame(input int last, input int mode);
        int  idx = 0;
        int  n = 0;
        bit  tog = 1'b1;
        bit  acc, ordy;
        logic signed [15:0] r, i;
        while (idx <= last && n < 8 * (last + 1) + 64) begin
            ordy = (mode == 0) ? tog : (mode == 1) ? 1'b1 : ($urandom_range(3) != 0);
            tog  = !tog;
            r    = ($urandom_range(7) == 0) ? 16'sh8000 : 16'($urandom);
            i    = ($urandom_range(7) == 0) ? 16'sh8000 : 16'($urandom);
            step(1, idx == 0, idx == last, r, i, ordy, 0, acc);
            if (acc) idx++;
            n++;
        end
        if (idx <= last) chk("frame_timeout", idx, last + 1);
    endtask

    initial begin
        vec_t tbl[11];
        bit   acc;
        int   lat;
        tbl[0]  = '{3, 4, 25, 1, 0};
        tbl[1]  = '{-32768, -32768, 64'd2147483648, 64'd16777215, 1};
        tbl[2]  = '{0, 0, 0, 0, 0};
        tbl[3]  = '{32767, 32767, 64'd2147352578, 64'd16777215, 1};
        tbl[4]  = '{-1, 1, 2, 0, 0};
        tbl[5]  = '{100, -200, 50000, 3125, 0};
        tbl[6]  = '{4095, 0, 16769025, 1048064, 0};
        tbl[7]  = '{16383, 16383, 536805378, 64'd16777215, 1};
        tbl[8]  = '{-4096, -4096, 33554432, 2097152, 0};
        tbl[9]  = '{16384, 0, 268435456, 64'd16777215, 1};
        tbl[10] = '{16383, 0, 268402689, 16775168, 0};
        b0.in_valid = 0; b0.in_sop = 0; b0.in_eop = 0;
        b0.in_real = 0; b0.in_imag = 0; b0.out_ready = 1;

        do_reset();
        step(1, 1, 0, 3, 4, 1, 0, acc);
        chk("lat_accept", acc, 1);
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            step(0, 0, 0, 0, 0, 1, 0, acc);
            if (last_oval) lat = k;
        end
        chk("latency", lat, 3);
        chk("lat_power", b0.out_power, 25);
        chk("lat_bin", b0.out_bin, 0);
        chk("lat_sop", b0.out_sop, 1);
        drain();

        for (int v = 0; v < 11; v++) begin
            step(1, 1, 0, 16'(tbl[v].r), 16'(tbl[v].i), 1, 0, acc);
            lat = 0;
            for (int k = 1; k <= 8 && lat == 0; k++) begin
                step(0, 0, 0, 0, 0, 1, 0, acc);
                if (last_oval) lat = k;
            end
            chk("tbl_latency", lat, 3);
            chk("tbl_power0", b0.out_power, tbl[v].p0);
            chk("tbl_sat0", b0.out_sat, 0);
            chk("tbl_power1", b1.out_power, tbl[v].p1);
            chk("tbl_sat1", b1.out_sat, tbl[v].s1);
        end
        drain();

        do_reset();
        run_frame(NB - 1, 0);
        drain();
        chk("full_frame_cnt", fcnt0, 1);
        chk("full_frame_err", ferr0, 0);

        do_reset();
        run_frame(500, 2);
        drain();
        chk("short_eop_err", ferr0, 1);
        idle(5, 0);
        chk("short_eop_sticky", ferr0, 1);
        idle(1, 1);
        idle(1, 0);
        chk("err_clr", ferr0, 0);
        run_frame(NB - 1, 1);
        drain();
        chk("clean_after_clr", ferr0, 0);
        chk("clean_frame_cnt", fcnt0, 2);

        do_reset();
        for (int k = 0; k < 10; k++) step(1, k == 0, 0, 16'($urandom), 16'($urandom), 1, 0, acc);
        do_reset();
        step(1, 0, 0, 7, -9, 1, 1, acc);
        drain();
        chk("no_sop_after_reset", ferr0, 1);

        do_reset();
        for (int f = 0; f < 3; f++) run_frame(NB - 1, 2);
        drain();
        chk("b2b_frame_cnt", fcnt0, 3);
        chk("b2b_frame_err", ferr0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
